// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Shared types for the backend fe_queue buffer: configuration selector and
// the fetch packet layout carried from the front end to the scheduler.
package bp_be_fe_queue_buffer_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int vaddr_width_p               = 39;
    localparam int branch_metadata_fwd_width_p = 36;

    typedef enum logic [1:0] {
        e_fe_fetch     = 2'b00,
        e_fe_exception = 2'b01
    } bp_fe_queue_type_e;

    typedef struct packed {
        bp_fe_queue_type_e                       msg_type;
        logic [vaddr_width_p-1:0]                pc;
        logic [branch_metadata_fwd_width_p-1:0]  branch_metadata_fwd;
    } bp_fe_queue_s;

endpackage

// File: rtl/bp_be_fe_queue_buffer_if.sv
// Fetch-packet handshake into the buffer (ready/valid) and out of it
// toward issue (valid/yumi). The buffer takes the slave side.
interface bp_be_fe_queue_buffer_if;
    import bp_be_fe_queue_buffer_pkg::*;

    bp_fe_queue_s fe_queue_i;
    logic         fe_queue_v_i;
    logic         fe_queue_ready_and_o;
    bp_fe_queue_s fe_queue_o;
    logic         fe_queue_v_o;
    logic         fe_queue_yumi_i;

    modport slave (
        input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
        output fe_queue_ready_and_o, fe_queue_o, fe_queue_v_o
    );

    modport master (
        output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
        input  fe_queue_ready_and_o, fe_queue_o, fe_queue_v_o
    );

endinterface

// File: rtl/bp_be_fe_queue_mem.sv
// 1-write / 1-read flop array with asynchronous read; data is never reset.
module bp_be_fe_queue_mem #(
    parameter int els_p   = 8,
    parameter int width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       w_v_i,
    input  logic [$clog2(els_p)-1:0]   w_addr_i,
    input  logic [width_p-1:0]         w_data_i,
    input  logic [$clog2(els_p)-1:0]   r_addr_i,
    output logic [width_p-1:0]         r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// Speculative-read fetch packet buffer with commit/roll/clear pointers.
// Optional same-cycle bypass of an incoming packet when read-empty: BP_BE_FE_QUEUE_BYPASS_EN.
module bp_be_fe_queue_buffer
    import bp_be_fe_queue_buffer_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int         els_p       = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    bp_be_fe_queue_buffer_if.slave         fe_queue,
    input  logic                           clr_v_i,
    input  logic                           roll_v_i,
    input  logic                           cmt_v_i,
    output logic                           empty_o
);

    localparam int idx_width_lp      = $clog2(els_p);
    localparam int ptr_width_lp      = idx_width_lp + 1;
    // Only the default configuration exists; any other collapses the packet width.
    localparam int fe_queue_width_lp = (bp_params_p == e_bp_default_cfg) ? $bits(bp_fe_queue_s) : 0;

    logic [ptr_width_lp-1:0]      wptr_r, rptr_r, cptr_r;
    logic [ptr_width_lp-1:0]      wptr_n, rptr_n, cptr_n;
    logic                         ready_r, ready_n;
    logic                         enq, deq, cmt, read_empty;
    logic [fe_queue_width_lp-1:0] rdata;

    assign enq        = fe_queue.fe_queue_v_i & ready_r & ~clr_v_i;
    assign deq        = fe_queue.fe_queue_yumi_i & ~clr_v_i & ~roll_v_i;
    assign cmt        = cmt_v_i & ~clr_v_i;
    assign read_empty = (rptr_r == wptr_r);

    // Clear collapses read and commit onto write; roll replays from the post-commit point.
    always_comb begin
        wptr_n  = wptr_r + ptr_width_lp'(enq);
        cptr_n  = clr_v_i ? wptr_r : (cptr_r + ptr_width_lp'(cmt));
        if (clr_v_i) begin
            rptr_n = wptr_r;
        end else if (roll_v_i) begin
            rptr_n = cptr_n;
        end else begin
            rptr_n = rptr_r + ptr_width_lp'(deq);
        end
        ready_n = ((wptr_n - cptr_n) != ptr_width_lp'(els_p));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            cptr_r  <= '0;
            ready_r <= 1'b1;
        end else begin
            wptr_r  <= wptr_n;
            rptr_r  <= rptr_n;
            cptr_r  <= cptr_n;
            ready_r <= ready_n;
        end
    end

    bp_be_fe_queue_mem #(
        .els_p   (els_p),
        .width_p (fe_queue_width_lp)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (enq),
        .w_addr_i (wptr_r[idx_width_lp-1:0]),
        .w_data_i (fe_queue.fe_queue_i),
        .r_addr_i (rptr_r[idx_width_lp-1:0]),
        .r_data_o (rdata)
    );

    assign fe_queue.fe_queue_ready_and_o = ready_r;
    assign empty_o                       = (cptr_r == wptr_r);

`ifdef BP_BE_FE_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass                = read_empty & enq;
    assign fe_queue.fe_queue_v_o = ~read_empty | bypass;
    assign fe_queue.fe_queue_o   = bypass ? fe_queue.fe_queue_i : bp_fe_queue_s'(rdata);
`else
    assign fe_queue.fe_queue_v_o = ~read_empty;
    assign fe_queue.fe_queue_o   = bp_fe_queue_s'(rdata);
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Bench for bp_be_fe_queue_buffer: directed vector table, hand sequences for
// full/roll/clear/async reset, and a queue-based scoreboard on every cycle.
module tb_bp_be_fe_queue_buffer;
    import bp_be_fe_queue_buffer_pkg::*;

    localparam int DEPTH = 8;

    typedef logic [vaddr_width_p-1:0] pc_t;

    typedef struct {
        logic v;
        pc_t  pc;
        logic yumi;
        logic cmt;
        logic roll;
        logic clr;
        logic use_exp;
        logic e_v;
        pc_t  e_pc;
        logic e_ready;
        logic e_empty;
    } vec_t;

    logic clk;
    logic reset_i;
    logic clr_v, roll_v, cmt_v;
    logic empty;

    bp_be_fe_queue_buffer_if fq ();

    bp_be_fe_queue_buffer #(
        .bp_params_p (e_bp_default_cfg),
        .els_p       (DEPTH)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .fe_queue (fq.slave),
        .clr_v_i  (clr_v),
        .roll_v_i (roll_v),
        .cmt_v_i  (cmt_v),
        .empty_o  (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Scoreboard: packets written but not yet read, and read but not yet committed.
    bp_fe_queue_s unread_q[$];
    bp_fe_queue_s issued_q[$];

    function automatic bp_fe_queue_s mk_pkt(input pc_t pc);
        bp_fe_queue_s p;
        p.msg_type            = e_fe_fetch;
        p.pc                  = pc;
        p.branch_metadata_fwd = branch_metadata_fwd_width_p'(pc) ^ 36'h5A5A5A5A5;
        return p;
    endfunction

    function automatic vec_t stim(input logic v, input pc_t pc, input logic yumi,
                                  input logic cmt, input logic roll, input logic clr);
        vec_t t;
        t.v = v; t.pc = pc; t.yumi = yumi; t.cmt = cmt; t.roll = roll; t.clr = clr;
        t.use_exp = 1'b0; t.e_v = 1'b0; t.e_pc = '0; t.e_ready = 1'b1; t.e_empty = 1'b1;
        return t;
    endfunction

    function automatic vec_t xvec(input logic v, input pc_t pc, input logic yumi, input logic cmt,
                                  input logic e_v, input pc_t e_pc, input logic e_empty);
        vec_t t;
        t = stim(v, pc, yumi, cmt, 1'b0, 1'b0);
        t.use_exp = 1'b1; t.e_v = e_v; t.e_pc = e_pc; t.e_ready = 1'b1; t.e_empty = e_empty;
        return t;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input bp_fe_queue_s act, input bp_fe_queue_s exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual_pc=%h required_pc=%h actual=%h required=%h",
                     name, act.pc, exp.pc, act, exp);
        end
    endtask

    // One clock cycle: drive just after posedge, compare at negedge, update model.
    task automatic cyc(input vec_t t, input string tag);
        logic m_v, m_ready, m_empty, acc;
        int   total;
        fq.fe_queue_v_i    = t.v;
        fq.fe_queue_i      = mk_pkt(t.pc);
        fq.fe_queue_yumi_i = t.yumi;
        cmt_v              = t.cmt;
        roll_v             = t.roll;
        clr_v              = t.clr;
        #4;
        total   = unread_q.size() + issued_q.size();
        m_v     = (unread_q.size() > 0);
        m_ready = (total < DEPTH);
        m_empty = (total == 0);
        chk_bit({tag, "_v"}, fq.fe_queue_v_o, m_v);
        if (m_v) chk_pkt({tag, "_pkt"}, fq.fe_queue_o, unread_q[0]);
        chk_bit({tag, "_ready"}, fq.fe_queue_ready_and_o, m_ready);
        chk_bit({tag, "_empty"}, empty, m_empty);
        if (t.use_exp) begin
            chk_bit({tag, "_tbl_v"}, fq.fe_queue_v_o, t.e_v);
            if (t.e_v) chk_pkt({tag, "_tbl_pkt"}, fq.fe_queue_o, mk_pkt(t.e_pc));
            chk_bit({tag, "_tbl_ready"}, fq.fe_queue_ready_and_o, t.e_ready);
            chk_bit({tag, "_tbl_empty"}, empty, t.e_empty);
        end
        acc = t.v && m_ready && !t.clr;
        if (t.clr) begin
            unread_q.delete();
            issued_q.delete();
        end else begin
            if (t.cmt && issued_q.size() > 0) void'(issued_q.pop_front());
            if (t.roll) begin
                while (issued_q.size() > 0) unread_q.push_front(issued_q.pop_back());
            end else if (t.yumi && unread_q.size() > 0) begin
                issued_q.push_back(unread_q.pop_front());
            end
            if (acc) unread_q.push_back(mk_pkt(t.pc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(stim(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0), tag);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (unread_q.size() > 0 && guard < 40) begin
            cyc(stim(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0), {tag, "_rd"});
            guard++;
        end
        while (issued_q.size() > 0 && guard < 40) begin
            cyc(stim(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0), {tag, "_cm"});
            guard++;
        end
        chk_bit({tag, "_drained"}, (guard < 40), 1'b1);
    endtask

    vec_t tbl[8];

    initial begin
        reset_i            = 1'b0;
        clr_v              = 1'b0;
        roll_v             = 1'b0;
        cmt_v              = 1'b0;
        fq.fe_queue_v_i    = 1'b0;
        fq.fe_queue_yumi_i = 1'b0;
        fq.fe_queue_i      = '0;

        // Three packets streamed with yumi, then three commits retire them.
        tbl[0] = xvec(1'b1, pc_t'('h80000000), 1'b0, 1'b0, 1'b0, '0,                   1'b1);
        tbl[1] = xvec(1'b1, pc_t'('h80000004), 1'b1, 1'b0, 1'b1, pc_t'('h80000000), 1'b0);
        tbl[2] = xvec(1'b1, pc_t'('h80000008), 1'b1, 1'b0, 1'b1, pc_t'('h80000004), 1'b0);
        tbl[3] = xvec(1'b0, '0,                 1'b1, 1'b0, 1'b1, pc_t'('h80000008), 1'b0);
        tbl[4] = xvec(1'b0, '0,                 1'b0, 1'b1, 1'b0, '0,                 1'b0);
        tbl[5] = xvec(1'b0, '0,                 1'b0, 1'b1, 1'b0, '0,                 1'b0);
        tbl[6] = xvec(1'b0, '0,                 1'b0, 1'b1, 1'b0, '0,                 1'b0);
        tbl[7] = xvec(1'b0, '0,                 1'b0, 1'b0, 1'b0, '0,                 1'b1);

        #1 reset_i = 1'b1;
        #2;
        chk_bit("rst_v", fq.fe_queue_v_o, 1'b0);
        chk_bit("rst_ready", fq.fe_queue_ready_and_o, 1'b1);
        chk_bit("rst_empty", empty, 1'b1);
        #9 reset_i = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) cyc(tbl[i], $sformatf("stream%0d", i));

        // Fill to capacity; the ninth offer must be refused.
        for (int i = 0; i < DEPTH; i++) cyc(stim(1'b1, pc_t'('h100 + 4 * i), 1'b0, 1'b0, 1'b0, 1'b0), "fill");
        chk_bit("full_ready_after_8th", fq.fe_queue_ready_and_o, 1'b0);
        cyc(stim(1'b1, pc_t'('hBAD), 1'b0, 1'b0, 1'b0, 1'b0), "full_offer");
        cyc(stim(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0), "full_read");
        chk_bit("full_ready_after_read", fq.fe_queue_ready_and_o, 1'b0);
        cyc(stim(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0), "full_cmt");
        chk_bit("full_ready_after_cmt", fq.fe_queue_ready_and_o, 1'b1);
        drain("full");

        // Roll back to the commit point and replay packets 2..4.
        cyc(stim(1'b1, pc_t'('h200), 1'b0, 1'b0, 1'b0, 1'b0), "roll_e0");
        cyc(stim(1'b1, pc_t'('h204), 1'b1, 1'b0, 1'b0, 1'b0), "roll_e1");
        cyc(stim(1'b1, pc_t'('h208), 1'b1, 1'b0, 1'b0, 1'b0), "roll_e2");
        cyc(stim(1'b1, pc_t'('h20C), 1'b1, 1'b0, 1'b0, 1'b0), "roll_e3");
        cyc(stim(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0), "roll_cmt");
        cyc(stim(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0), "roll_go");
        chk_bit("roll_v_next", fq.fe_queue_v_o, 1'b1);
        chk_pkt("roll_pkt_next", fq.fe_queue_o, mk_pkt(pc_t'('h204)));
        for (int i = 0; i < 3; i++) cyc(stim(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0), "roll_replay");
        drain("roll");

        // Clear with a colliding enqueue and yumi while five entries are held.
        for (int i = 0; i < 5; i++) cyc(stim(1'b1, pc_t'('h300 + 4 * i), 1'b0, 1'b0, 1'b0, 1'b0), "clr_fill");
        cyc(stim(1'b1, pc_t'('h1000), 1'b1, 1'b0, 1'b0, 1'b1), "clr_go");
        chk_bit("clr_v_next", fq.fe_queue_v_o, 1'b0);
        chk_bit("clr_empty_next", empty, 1'b1);
        idle("clr_idle");
        cyc(stim(1'b1, pc_t'('h2000), 1'b0, 1'b0, 1'b0, 1'b0), "clr_enq");
        chk_pkt("clr_first_after", fq.fe_queue_o, mk_pkt(pc_t'('h2000)));
        drain("clr");

        // Random traffic long enough to wrap the pointers several times.
        for (int i = 0; i < 80; i++) begin
            logic v, y, c, r;
            v = ($urandom_range(3) != 0);
            y = (unread_q.size() > 0) && ($urandom_range(3) != 0);
            c = (issued_q.size() > 0) && ($urandom_range(2) != 0);
            r = ($urandom_range(15) == 0);
            cyc(stim(v, pc_t'('h40000 + 4 * i), y, c, r, 1'b0), "rand");
        end
        drain("rand");

        // Asynchronous reset between edges with three entries held.
        for (int i = 0; i < 3; i++) cyc(stim(1'b1, pc_t'('h400 + 4 * i), 1'b0, 1'b0, 1'b0, 1'b0), "arst_fill");
        fq.fe_queue_v_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk_bit("arst_v", fq.fe_queue_v_o, 1'b0);
        chk_bit("arst_ready", fq.fe_queue_ready_and_o, 1'b1);
        chk_bit("arst_empty", empty, 1'b1);
        unread_q.delete();
        issued_q.delete();
        #2 reset_i = 1'b0;
        @(posedge clk);
        #1;
        cyc(stim(1'b1, pc_t'('h500), 1'b0, 1'b0, 1'b0, 1'b0), "arst_enq");
        chk_pkt("arst_first_read", fq.fe_queue_o, mk_pkt(pc_t'('h500)));
        drain("arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
